// File: rtl/vga_fb_scheduler.sv
// rtl/vga_fb_scheduler.sv - framebuffer RAM arbiter between VGA line prefetch and pixel writer
module vga_fb_scheduler #(
    parameter int DATA_W   = 6,
    parameter int ADDR_W   = 16,
    parameter int LAST_ROW = 239
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic              i_line_start,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic              o_fb_we,
    output logic [DATA_W-1:0] o_fb_wdata,
    input  logic [DATA_W-1:0] i_fb_rdata,
    output logic              o_lb_we,
    output logic              o_lb_bank,
    output logic [7:0]        o_lb_addr,
    output logic [DATA_W-1:0] o_lb_wdata,
    output logic              o_disp_bank,
    output logic              o_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FETCH, S_DRAIN} state_t;

    localparam logic [9:0] LAST_TRIG_LINE = 10'(2 * LAST_ROW - 1);

    state_t     state, state_nxt;
    logic [9:0] lc;
    logic [9:0] lc_inc;
    logic       pending;
    logic       bank;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] trig_row;
    logic       rd_issued;
    logic       trig_line;
    logic       trig;
    logic       busy;
    logic       start_fetch;

    // Row n is fetched on VGA line 2n-1 so it is ready when line 2n starts.
    assign lc_inc      = lc + 10'd1;
    assign trig_line   = i_line_start && !i_frame_start && lc_inc[0] && (lc_inc <= LAST_TRIG_LINE);
    assign trig        = i_frame_start || trig_line;
    assign trig_row    = i_frame_start ? 8'd0 : 8'((lc_inc + 10'd1) >> 1);
    assign busy        = (state == S_FETCH) || (state == S_DRAIN);
    assign start_fetch = (state_nxt == S_FETCH) && (state != S_FETCH);

    assign o_disp_bank = lc[1];
    // The RAM output register acts as the line-buffer data register.
    assign o_lb_wdata  = o_lb_we ? i_fb_rdata : '0;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A trigger seen in IDLE holds off the writer so the fetch always wins.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    state_nxt = S_FETCH;
                end else if (!trig && i_wr_req) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: state_nxt = (pending || trig) ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (col == 8'hFF) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lc         <= '0;
            pending    <= 1'b0;
            bank       <= 1'b0;
            row        <= '0;
            col        <= '0;
            rd_issued  <= 1'b0;
            o_overrun  <= 1'b0;
            o_wr_ack   <= 1'b0;
            o_fb_we    <= 1'b0;
            o_fb_addr  <= '0;
            o_fb_wdata <= '0;
            o_lb_we    <= 1'b0;
            o_lb_bank  <= 1'b0;
            o_lb_addr  <= '0;
        end else begin
            if (i_frame_start) begin
                lc <= '0;
            end else if (i_line_start) begin
                lc <= lc_inc;
            end

            if (trig && busy) begin
                o_overrun <= 1'b1;
            end
            if (trig && !busy) begin
                row  <= trig_row;
                bank <= trig_row[0];
            end

            if (start_fetch) begin
                pending <= 1'b0;
                col     <= '0;
            end else begin
                if (trig && !busy) begin
                    pending <= 1'b1;
                end
                if (state == S_FETCH) begin
                    col <= col + 8'd1;
                end
            end

            o_fb_we  <= (state == S_WRITE);
            o_wr_ack <= (state == S_WRITE);
            if (state == S_WRITE) begin
                o_fb_addr  <= i_wr_addr;
                o_fb_wdata <= i_wr_data;
            end else if (state == S_FETCH) begin
                o_fb_addr <= ADDR_W'({row, col});
            end

            // Line-buffer write trails the read address by one clock.
            rd_issued <= (state == S_FETCH);
            o_lb_we   <= rd_issued;
            if (rd_issued) begin
                o_lb_addr <= o_fb_addr[7:0];
                o_lb_bank <= bank;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb/tb_vga_fb_scheduler.sv - randomized self-checking bench for vga_fb_scheduler
module tb_vga_fb_scheduler;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_frame_start = 1'b0;
    logic        i_line_start = 1'b0;
    logic        i_wr_req = 1'b0;
    logic [15:0] i_wr_addr = '0;
    logic [5:0]  i_wr_data = '0;
    logic        o_wr_ack;
    logic [15:0] o_fb_addr;
    logic        o_fb_we;
    logic [5:0]  o_fb_wdata;
    logic [5:0]  i_fb_rdata;
    logic        o_lb_we;
    logic        o_lb_bank;
    logic [7:0]  o_lb_addr;
    logic [5:0]  o_lb_wdata;
    logic        o_disp_bank;
    logic        o_overrun;

    typedef struct {
        int         cyc;
        logic       bank;
        logic [7:0] col;
        logic [5:0] data;
    } lb_ev_t;

    lb_ev_t     lb_q[$];
    logic [5:0] ram [0:65535];
    logic [5:0] ref_mem [0:65535];
    logic       ram_loaded = 1'b0;
    int         cyc = 0;
    int         we_cnt = 0;
    int         ref_lc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    vga_fb_scheduler #(.DATA_W(6), .ADDR_W(16), .LAST_ROW(239)) dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_frame_start (i_frame_start),
        .i_line_start  (i_line_start),
        .i_wr_req      (i_wr_req),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .o_wr_ack      (o_wr_ack),
        .o_fb_addr     (o_fb_addr),
        .o_fb_we       (o_fb_we),
        .o_fb_wdata    (o_fb_wdata),
        .i_fb_rdata    (i_fb_rdata),
        .o_lb_we       (o_lb_we),
        .o_lb_bank     (o_lb_bank),
        .o_lb_addr     (o_lb_addr),
        .o_lb_wdata    (o_lb_wdata),
        .o_disp_bank   (o_disp_bank),
        .o_overrun     (o_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with one clock read latency.
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int a = 0; a < 65536; a++) ram[a] <= ref_mem[a];
            ram_loaded <= 1'b1;
        end else if (o_fb_we) begin
            ram[o_fb_addr] <= o_fb_wdata;
        end
        i_fb_rdata <= ram[o_fb_addr];
    end

    always @(negedge clk) begin
        if (i_rst_n) begin
            if (o_lb_we) lb_q.push_back(lb_ev_t'{cyc, o_lb_bank, o_lb_addr, o_lb_wdata});
            if (o_fb_we) we_cnt <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({o_fb_addr, o_fb_we, o_fb_wdata, o_lb_we, o_lb_bank, o_lb_addr,
                    o_lb_wdata, o_wr_ack, o_disp_bank, o_overrun});
    endfunction

    task automatic check_fetch(input int t0, input int row, input logic exp, input int base);
        int n;
        int bad;
        n = lb_q.size() - base;
        if (!exp) begin
            check("lb_idle_count", 64'(n), 64'd0);
            return;
        end
        check("lb_count", 64'(n), 64'd256);
        if (n == 256) begin
            check("lb_first_latency", 64'(lb_q[base].cyc - t0), 64'd3);
            check("lb_last_latency", 64'(lb_q[base + 255].cyc - t0), 64'd258);
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                if (lb_q[base + i].bank !== 1'(row % 2) || lb_q[base + i].col !== 8'(i) ||
                    lb_q[base + i].data !== ref_mem[row * 256 + i] ||
                    lb_q[base + i].cyc != lb_q[base].cyc + i)
                    bad++;
            end
            check("lb_content", 64'(bad), 64'd0);
        end
    endtask

    task automatic line_step(input logic f, input logic l);
        int   t0;
        int   base;
        int   row;
        logic trig;
        base = lb_q.size();
        @(negedge clk);
        i_frame_start = f;
        i_line_start  = l;
        t0 = cyc + 1;
        @(negedge clk);
        i_frame_start = 1'b0;
        i_line_start  = 1'b0;
        if (f) ref_lc = 0;
        else if (l) ref_lc = ref_lc + 1;
        trig = f || (l && (ref_lc % 2 == 1) && ref_lc <= 477);
        row  = f ? 0 : (ref_lc + 1) / 2;
        check("disp_bank", 64'(o_disp_bank), 64'((ref_lc / 2) % 2));
        repeat (trig ? 262 : 3) @(negedge clk);
        check_fetch(t0, row, trig, base);
    endtask

    task automatic wait_ack();
        int w;
        w = 0;
        @(negedge clk);
        while (!o_wr_ack && w < 600) begin
            @(negedge clk);
            w++;
        end
        check("wr_ack_seen", 64'(o_wr_ack), 64'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] wa [8];
        logic [5:0]  wd [8];
        logic [5:0]  cd;
        int          t0;
        int          base;

        for (int a = 0; a < 65536; a++) ref_mem[a] = 6'($urandom);

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        i_rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", all_outs(), 64'd0);

        // Back-to-back writes, the first held from its first cycle.
        wa[0] = 16'h1234;
        wd[0] = 6'h2A;
        for (int j = 1; j < 8; j++) begin
            wa[j] = {8'h00, 8'($urandom)};
            wd[j] = 6'($urandom);
        end
        @(negedge clk);
        i_wr_req  = 1'b1;
        i_wr_addr = wa[0];
        i_wr_data = wd[0];
        t0 = cyc + 1;
        for (int j = 0; j < 8; j++) begin
            wait_ack();
            check("wr_ack_time", 64'(cyc - t0), 64'(1 + 2 * j));
            check("wr_fb_we", 64'(o_fb_we), 64'd1);
            check("wr_fb_addr", 64'(o_fb_addr), 64'(wa[j]));
            check("wr_fb_data", 64'(o_fb_wdata), 64'(wd[j]));
            ref_mem[wa[j]] = wd[j];
            if (j < 7) begin
                i_wr_addr = wa[j + 1];
                i_wr_data = wd[j + 1];
            end else begin
                i_wr_req = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        check("wr_count", 64'(we_cnt), 64'd8);

        // Full frame of line pulses.
        line_step(1'b1, 1'b0);
        for (int l = 1; l <= 524; l++) begin
            line_step(1'b0, 1'b1);
            if (ref_lc == 477) check("last_row_addr", 64'(o_fb_addr), 64'hEFFF);
        end
        check("tail_fb_addr_idle", 64'(o_fb_addr), 64'hEFFF);
        check("tail_no_writes", 64'(we_cnt), 64'd8);
        check("no_overrun", 64'(o_overrun), 64'd0);

        // Write request and fetch trigger in the same clock, plus an overrun.
        cd = 6'($urandom);
        base = lb_q.size();
        @(negedge clk);
        i_wr_req      = 1'b1;
        i_wr_addr     = 16'h0005;
        i_wr_data     = cd;
        i_frame_start = 1'b1;
        t0 = cyc + 1;
        ref_lc = 0;
        @(negedge clk);
        i_frame_start = 1'b0;
        repeat (98) @(negedge clk);
        i_frame_start = 1'b1;
        @(negedge clk);
        i_frame_start = 1'b0;
        wait_ack();
        check("contend_ack_time", 64'(cyc - t0), 64'd260);
        check("contend_fb_addr", 64'(o_fb_addr), 64'h0005);
        check("contend_fb_data", 64'(o_fb_wdata), 64'(cd));
        i_wr_req = 1'b0;
        check_fetch(t0, 0, 1'b1, base);
        ref_mem[16'h0005] = cd;
        check("overrun_set", 64'(o_overrun), 64'd1);
        repeat (5) @(negedge clk);
        check("overrun_sticky", 64'(o_overrun), 64'd1);

        // Reset in the middle of a fetch.
        @(negedge clk);
        i_frame_start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        i_frame_start = 1'b0;
        while (cyc < t0 + 102) @(negedge clk);
        check("midfetch_col100", 64'(o_fb_addr), 64'h0064);
        i_rst_n = 1'b0;
        #1;
        check("midfetch_reset_outputs", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        check("held_reset_outputs", all_outs(), 64'd0);
        i_rst_n = 1'b1;
        ref_lc = 0;
        base = lb_q.size();
        repeat (300) @(negedge clk);
        check_fetch(0, 0, 1'b0, base);
        check("post_abort_overrun", 64'(o_overrun), 64'd0);
        line_step(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
